mux3_rr_sched: RTL

- Round-robin scheduler that shares one mux3_3 datapath (3 sources × 3 bits, 2-bit select) between three valid/ready requesters.
- Each cycle it picks at most one requester and drives the mux select. The mux result is captured in a single-entry output register with a valid/ready handshake.
- Sits in the ALU operand path, upstream of the consumer that takes the selected 3-bit operand.

---
 rtl/mux_sched_pkg.sv | 10 +
 rtl/mux3_3.sv | 16 +
 rtl/rr_pick3.sv | 28 ++
 rtl/mux3_rr_sched.sv | 86 ++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared sizes and types for the three-way round-robin operand scheduler.
package mux_sched_pkg;
  localparam int N_REQ  = 3;
  localparam int DATA_W = 3;

  typedef logic [1:0] req_idx_t;

  // Select value that routes the zero pad of the shared mux.
  localparam req_idx_t SEL_ZERO = 2'd3;
endpackage

// File: rtl/mux3_3.sv
// Three-source, 3-bit mux; select value 3 yields zero.
module mux3_3 (
  input  logic [8:0] a,
  input  logic [1:0] s,
  output logic [2:0] y
);
  always_comb begin
    y = 3'd0;
    case (s)
      2'd0:    y = a[2:0];
      2'd1:    y = a[5:3];
      2'd2:    y = a[8:6];
      default: y = 3'd0;
    endcase
  end
endmodule

// File: rtl/rr_pick3.sv
// Combinational round-robin picker: searches last+1, last+2, last+3 (mod 3).
module rr_pick3
  import mux_sched_pkg::*;
(
  input  logic [2:0] valid_i,
  input  req_idx_t   last_i,
  output req_idx_t   winner_o,
  output logic       any_o
);
  // Mod-3 increment done as a 2-bit compare, so an index never reaches 3.
  function automatic req_idx_t inc3(input req_idx_t x);
    return (x >= 2'd2) ? 2'd0 : req_idx_t'(x + 2'd1);
  endfunction

  req_idx_t cand1, cand2, cand3;

  assign cand1 = inc3(last_i);
  assign cand2 = inc3(cand1);
  assign cand3 = inc3(cand2);
  assign any_o = |valid_i;

  always_comb begin
    winner_o = cand3;
    if (valid_i[cand1])      winner_o = cand1;
    else if (valid_i[cand2]) winner_o = cand2;
    else                     winner_o = cand3;
  end
endmodule

// File: rtl/mux3_rr_sched.sv
// Round-robin sharing of one mux3_3 between three valid/ready requesters,
// with a single-entry output register that can refill in the cycle it drains.
module mux3_rr_sched
  import mux_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          in_valid,
  input  logic [N_REQ*DATA_W-1:0]   in_data,
  output logic [N_REQ-1:0]          in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [1:0]                out_src,
  output logic [1:0]                mux_sel
);
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  req_idx_t          out_src_q,   out_src_d;
  req_idx_t          last_grant_q, last_grant_d;

  req_idx_t          winner;
  logic              any_raw;
  logic              any_req;
  logic              load;
  logic [DATA_W-1:0] mux_y;

  rr_pick3 u_pick (
    .valid_i  (in_valid),
    .last_i   (last_grant_q),
    .winner_o (winner),
    .any_o    (any_raw)
  );

  // Requests are ignored while reset is held so nothing is granted then.
  assign any_req = any_raw & rst;
  assign load    = !out_valid_q || out_ready;
  assign mux_sel = any_req ? winner : SEL_ZERO;

  always_comb begin
    in_ready = '0;
    if (load && any_req) in_ready = 3'(3'b001 << winner);
  end

  mux3_3 u_mux (
    .a (in_data),
    .s (mux_sel),
    .y (mux_y)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (any_req) begin
        out_valid_d  = 1'b1;
        out_data_d   = mux_y;
        out_src_d    = winner;
        last_grant_d = winner;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
  end

  // last_grant resets to 2 so requester 0 holds first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= 2'd0;
      last_grant_q <= 2'd2;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
endmodule
